serial_add_sub_ctrl: RTL and testbench
======================================

# serial_add_sub_ctrl

Bit-serial sequencer for the 1-bit adder/subtractor cell. It latches two WIDTH-bit operands and a mode on a start request, then feeds them LSB-first through one add/sub bit cell, one bit per clock. It holds the carry/borrow in a flop between bits and presents the full-width result with a done pulse. It sits between a requesting datapath and the shared single-bit cell, trading latency for area.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous and active-low
- start  in  1  request; sampled only when busy=0
- mode  in  1  1 = add (a+b+cin), 0 = subtract (a-b-cin); same polarity as cell en
- a  in  WIDTH  minuend / addend
- b  in  WIDTH  subtrahend / addend
- cin  in  1  initial carry (add) or borrow (sub) into bit 0
- busy  out  1  high while bits are being processed
- done  out  1  one-cycle pulse; result/cout valid
- result  out  WIDTH  sum or difference, registered
- cout  out  1  final carry (add) or borrow (sub) out of MSB
- ovf  out  1  signed overflow; present only with SERIAL_ADD_SUB_OVF_EN

## Operation
- Bit cell function, per bit i with carry/borrow c:
  - op1 = a[i]^b[i]^c
  - add: op2 = a·b | a·c | b·c
  - sub: op2 = ~a·b | ~a·c | b·c
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 → latch a, b, mode, cin into internal regs; clear bit counter → RUN.
  - RUN: each cycle process bit cnt; shift op1 into internal shift register; c ← op2; cnt++. After bit WIDTH-1 → DONE; load result ← shift reg, cout ← final op2.
  - DONE: done=1 for this cycle only. start=1 → accepted as in IDLE → RUN (back-to-back). Otherwise → IDLE.
- start while busy=1 is ignored; no queueing.
- Input changes during RUN do not affect the operation in progress (operands are latched).
- result/cout/ovf hold their last value from the DONE load until the next completion; they do not change during RUN.
- Arithmetic is modulo 2^WIDTH. Subtract borrow semantics: cout=1 iff a < b+cin as unsigned.
- Reset (asynchronous, any state, including mid-RUN):
  - state=IDLE, busy=0, done=0, result=0, cout=0, ovf=0, internal regs=0.
  - An aborted operation produces no done.

## Timing
- Edge E0 samples start=1 → busy=1 from E0.
- Bits 0..WIDTH-1 are processed at edges E1..EWIDTH.
- At EWIDTH: busy=0, done=1, result/cout valid; result is available WIDTH cycles after the start-sampling edge.
- At EWIDTH+1: done=0. Throughput is one operation per WIDTH+1 cycles (back-to-back start in DONE). busy and done are never high together.
- All outputs are registered; there is no combinational input→output path.

## Configuration
- SERIAL_ADD_SUB_OVF_EN defined:
  - Port ovf exists; it is loaded with result at DONE.
  - add: ovf = (a[MSB]==b[MSB]) & (result[MSB]!=a[MSB]).
  - sub: ovf = (a[MSB]!=b[MSB]) & (result[MSB]!=a[MSB]).
  - Operands are those latched at start; reset value 0.
- Not defined: no ovf port and no overflow logic; all other behaviour is identical.

## Test plan
- WIDTH=8, mode=1, a=0x35, b=0x4A, cin=0, start pulse → busy for 8 cycles, done 8 cycles after start edge, result=0x7F, cout=0, ovf=0.
- mode=1, a=0xFF, b=0x01, cin=0 → result=0x00, cout=1, ovf=0. mode=1, a=0x7F, b=0x01 → result=0x80, cout=0, ovf=1.
- mode=0, a=0x10, b=0x20, cin=0 → result=0xF0, cout=1, ovf=0. mode=0, a=0x05, b=0x03, cin=1 → result=0x01, cout=0. mode=0, a=0x80, b=0x01 → result=0x7F, cout=0, ovf=1.
- Start accepted, then at cycle 3 drive start=1 with a=0xAA, b=0x55, mode=0 → ignored; original result returned. Start held high in DONE cycle → new operation begins with no idle cycle.
- Reset asserted asynchronously mid-RUN (cycle 4) → busy, done, result, cout, ovf drop to 0 immediately; no done pulse follows. Next start completes normally.

Source files
------------

// File: rtl/serial_add_sub_ctrl.sv
// Bit-serial add/subtract sequencer: latches operands on start and runs them LSB-first
// through one add/sub bit cell. Define SERIAL_ADD_SUB_OVF_EN to add the signed-overflow output.
module serial_add_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_ADD_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, sh_r, result_nxt;
  logic             mode_r, c_r;
  logic [CNT_W-1:0] cnt_r;
  logic             accept, last_bit, op1, op2;

  // Returns {carry/borrow out, sum/difference bit}; add selects the carry form.
  function automatic logic [1:0] bit_cell(input logic ai, input logic bi,
                                          input logic ci, input logic add);
    logic s, c;
    s = ai ^ bi ^ ci;
    if (add) c = (ai & bi) | (ai & ci) | (bi & ci);
    else     c = (~ai & bi) | (~ai & ci) | (bi & ci);
    return {c, s};
  endfunction

  assign {op2, op1}  = bit_cell(a_r[cnt_r], b_r[cnt_r], c_r, mode_r);
  assign last_bit    = (cnt_r == CNT_W'(WIDTH - 1));
  assign accept      = start && (state != RUN);
  // New bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
  assign result_nxt  = {op1, sh_r[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      sh_r   <= '0;
      mode_r <= 1'b0;
      c_r    <= 1'b0;
      cnt_r  <= '0;
      result <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_r    <= a;
      b_r    <= b;
      mode_r <= mode;
      c_r    <= cin;
      cnt_r  <= '0;
      sh_r   <= '0;
    end else if (state == RUN) begin
      sh_r  <= result_nxt;
      c_r   <= op2;
      cnt_r <= cnt_r + CNT_W'(1);
      if (last_bit) begin
        result <= result_nxt;
        cout   <= op2;
      end
    end
  end

`ifdef SERIAL_ADD_SUB_OVF_EN
  logic ovf_nxt;

  // op1 on the last bit is the result MSB.
  always_comb begin
    if (mode_r) ovf_nxt = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (op1 != a_r[WIDTH-1]);
    else        ovf_nxt = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (op1 != a_r[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          ovf <= 1'b0;
    else if (state == RUN && last_bit)   ovf <= ovf_nxt;
  end
`endif

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// Directed bench for serial_add_sub_ctrl (WIDTH=8) with hand-computed expected results.
module tb_serial_add_sub_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] result;
  logic [W-1:0] prev_result;
`ifdef SERIAL_ADD_SUB_OVF_EN
  logic         ovf;
`endif

  int n_vec = 0;
  int n_bad = 0;

  serial_add_sub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout)
`ifdef SERIAL_ADD_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ovf(input string tag, input logic exp);
`ifdef SERIAL_ADD_SUB_OVF_EN
    check(tag, {31'd0, ovf}, {31'd0, exp});
`else
    if (exp === 1'bx) $display("unreachable %s", tag);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic c);
    start = 1'b1; mode = m; a = av; b = bv; cin = c;
  endtask

  // Caller has already driven start with operands. inject>0 drives a rogue start mid-run;
  // chained=1 leaves the trailing idle check to the following operation.
  task automatic run_op(input string tag, input logic [W-1:0] exp_res, input logic exp_cout,
                        input logic exp_ovf, input int inject, input bit chained);
    tick();
    start = 1'b0;
    check({tag, ".busy_e0"}, {31'd0, busy}, 32'd1);
    check({tag, ".done_e0"}, {31'd0, done}, 32'd0);
    for (int k = 1; k < W; k++) begin
      if (k == inject) drive(1'b0, 8'hAA, 8'h55, 1'b0);
      else             start = 1'b0;
      tick();
      check({tag, ".busy_run"}, {31'd0, busy}, 32'd1);
      check({tag, ".done_run"}, {31'd0, done}, 32'd0);
      check({tag, ".hold_run"}, {24'd0, result}, {24'd0, prev_result});
    end
    start = 1'b0;
    tick();
    check({tag, ".busy_fin"}, {31'd0, busy}, 32'd0);
    check({tag, ".done_fin"}, {31'd0, done}, 32'd1);
    check({tag, ".result"}, {24'd0, result}, {24'd0, exp_res});
    check({tag, ".cout"}, {31'd0, cout}, {31'd0, exp_cout});
    check_ovf({tag, ".ovf"}, exp_ovf);
    prev_result = exp_res;
    if (!chained) begin
      tick();
      check({tag, ".done_drop"}, {31'd0, done}, 32'd0);
      check({tag, ".busy_idle"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    prev_result = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.result", {24'd0, result}, 32'd0);
    check("rst.cout", {31'd0, cout}, 32'd0);
    check_ovf("rst.ovf", 1'b0);
    rst_n = 1'b1;
    tick();

    drive(1'b1, 8'h35, 8'h4A, 1'b0); run_op("add35_4a", 8'h7F, 1'b0, 1'b0, 0, 1'b0);
    drive(1'b1, 8'hFF, 8'h01, 1'b0); run_op("addff_01", 8'h00, 1'b1, 1'b0, 0, 1'b0);
    drive(1'b1, 8'h7F, 8'h01, 1'b0); run_op("add7f_01", 8'h80, 1'b0, 1'b1, 0, 1'b0);
    drive(1'b0, 8'h10, 8'h20, 1'b0); run_op("sub10_20", 8'hF0, 1'b1, 1'b0, 0, 1'b0);
    drive(1'b0, 8'h05, 8'h03, 1'b1); run_op("sub05_03c", 8'h01, 1'b0, 1'b0, 0, 1'b0);
    drive(1'b0, 8'h80, 8'h01, 1'b0); run_op("sub80_01", 8'h7F, 1'b0, 1'b1, 0, 1'b0);

    // Rogue start at cycle 3 must be ignored: 0x12+0x34+1 = 0x47.
    drive(1'b1, 8'h12, 8'h34, 1'b1); run_op("ignore", 8'h47, 1'b0, 1'b0, 3, 1'b0);

    // Back-to-back: 0x01+0x02+1 = 0x04, then start held in DONE: 0x03-0x05 = 0xFE, borrow.
    drive(1'b1, 8'h01, 8'h02, 1'b1); run_op("b2b_first", 8'h04, 1'b0, 1'b0, 0, 1'b1);
    drive(1'b0, 8'h03, 8'h05, 1'b0); run_op("b2b_second", 8'hFE, 1'b1, 1'b0, 0, 1'b0);

    // Asynchronous reset in the middle of cycle 4 of a run.
    drive(1'b1, 8'h0F, 8'h0F, 1'b0);
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("abort.busy", {31'd0, busy}, 32'd0);
    check("abort.done", {31'd0, done}, 32'd0);
    check("abort.result", {24'd0, result}, 32'd0);
    check("abort.cout", {31'd0, cout}, 32'd0);
    check_ovf("abort.ovf", 1'b0);
    #1 rst_n = 1'b1;
    prev_result = '0;
    for (int k = 0; k < W + 2; k++) begin
      tick();
      check("abort.no_done", {31'd0, done}, 32'd0);
    end
    drive(1'b1, 8'h35, 8'h4A, 1'b0); run_op("after_abort", 8'h7F, 1'b0, 1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
